// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: owns the register-file write port, granting core writeback first and draining late aux results from a small FIFO.
// Build option RF_WB_BYPASS_EN: an aux result meeting an empty FIFO and an idle core is written in the same cycle.
//
// state   | meaning
// S_NORM  | core has priority; live aux head drains into idle write-port cycles
// S_FORCE | aux head starved; core is stalled and the head is forced out
module rf_wb_arbiter #(
    parameter int ADDR       = 5,
    parameter int SIZE       = 32,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1,
    localparam int SW = $clog2(STARVE_MAX + 1)
) (
    input  logic            Clk,
    input  logic            Clr,
    input  logic            Core_Wr_En,
    input  logic [ADDR-1:0] Core_W_Addr,
    input  logic [SIZE-1:0] Core_W_Data,
    input  logic            Aux_Valid,
    input  logic [ADDR-1:0] Aux_W_Addr,
    input  logic [SIZE-1:0] Aux_W_Data,
    output logic            Aux_Ready,
    input  logic [ADDR-1:0] R_Addr_A,
    input  logic [ADDR-1:0] R_Addr_B,
    output logic            Hazard_A,
    output logic            Hazard_B,
    output logic            Stall_Req,
    output logic [CW-1:0]   Pend_Cnt,
    output logic            Write_Reg,
    output logic [ADDR-1:0] W_Addr,
    output logic [SIZE-1:0] W_Data
);

    typedef enum logic [0:0] {S_NORM, S_FORCE} state_t;

    state_t          state;
    logic [ADDR-1:0] fifo_addr [DEPTH];
    logic [SIZE-1:0] fifo_data [DEPTH];
    logic [DEPTH-1:0] fifo_live;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   cnt;
    logic [SW-1:0]   starve_cnt;
    logic [SW-1:0]   starve_nxt;

    logic empty;
    logic full;
    logic head_live;
    logic bypass;
    logic push;
    logic pop;
    logic core_grant;
    logic push_killed;
    logic hit_a;
    logic hit_b;

    assign empty     = (cnt == '0);
    assign full      = (cnt == CW'(DEPTH));
    assign head_live = !empty && fifo_live[rd_ptr];

`ifdef RF_WB_BYPASS_EN
    assign bypass = !Clr && (state == S_NORM) && empty && !Core_Wr_En && Aux_Valid;
`else
    assign bypass = 1'b0;
`endif

    assign Aux_Ready   = !full && !Clr;
    assign push        = Aux_Valid && Aux_Ready && !bypass;
    assign push_killed = core_grant && (Aux_W_Addr == Core_W_Addr);
    assign Stall_Req   = !Clr && (state == S_FORCE);
    assign Pend_Cnt    = cnt;

    always_comb begin
        Write_Reg  = 1'b0;
        W_Addr     = '0;
        W_Data     = '0;
        pop        = 1'b0;
        core_grant = 1'b0;
        if (!Clr) begin
            if (state == S_FORCE) begin
                // Core write is ignored here; the core re-presents it, so no kill.
                pop = !empty;
                if (head_live) begin
                    Write_Reg = 1'b1;
                    W_Addr    = fifo_addr[rd_ptr];
                    W_Data    = fifo_data[rd_ptr];
                end
            end else if (Core_Wr_En) begin
                core_grant = 1'b1;
                Write_Reg  = 1'b1;
                W_Addr     = Core_W_Addr;
                W_Data     = Core_W_Data;
                pop        = !empty && !fifo_live[rd_ptr];
            end else if (!empty) begin
                pop = 1'b1;
                if (head_live) begin
                    Write_Reg = 1'b1;
                    W_Addr    = fifo_addr[rd_ptr];
                    W_Data    = fifo_data[rd_ptr];
                end
            end else if (bypass) begin
                Write_Reg = 1'b1;
                W_Addr    = Aux_W_Addr;
                W_Data    = Aux_W_Data;
            end
        end
    end

    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_live[i] && (fifo_addr[i] == R_Addr_A)) hit_a = 1'b1;
            if (fifo_live[i] && (fifo_addr[i] == R_Addr_B)) hit_b = 1'b1;
        end
    end

    assign Hazard_A = hit_a && !Clr;
    assign Hazard_B = hit_b && !Clr;

    always_comb begin
        starve_nxt = starve_cnt;
        if ((state == S_FORCE) || pop || empty)
            starve_nxt = '0;
        else if (head_live && Core_Wr_En)
            starve_nxt = starve_cnt + SW'(1);
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            fifo_live  <= '0;
            starve_cnt <= '0;
            state      <= S_NORM;
        end else begin
            if (push) begin
                fifo_addr[wr_ptr] <= Aux_W_Addr;
                fifo_data[wr_ptr] <= Aux_W_Data;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            cnt <= cnt + CW'(push) - CW'(pop);
            // Live bits are only kept for occupied slots, so hazards need no occupancy mask.
            for (int i = 0; i < DEPTH; i++) begin
                if (push && (wr_ptr == PW'(i)))
                    fifo_live[i] <= !push_killed;
                else if (pop && (rd_ptr == PW'(i)))
                    fifo_live[i] <= 1'b0;
                else if (core_grant && (fifo_addr[i] == Core_W_Addr))
                    fifo_live[i] <= 1'b0;
            end
            starve_cnt <= starve_nxt;
            case (state)
                S_NORM:  if (starve_nxt == SW'(STARVE_MAX)) state <= S_FORCE;
                S_FORCE: state <= S_NORM;
                default: state <= S_NORM;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed scenarios for rf_wb_arbiter followed by random traffic checked
// against a queue-level model of the write-port rules.
`timescale 1ns/1ps
module tb_rf_wb_arbiter;
    localparam int ADDR       = 5;
    localparam int SIZE       = 32;
    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 8;
    localparam int CW         = $clog2(DEPTH) + 1;
`ifdef RF_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            Clk = 1'b0;
    logic            Clr;
    logic            Core_Wr_En;
    logic [ADDR-1:0] Core_W_Addr;
    logic [SIZE-1:0] Core_W_Data;
    logic            Aux_Valid;
    logic [ADDR-1:0] Aux_W_Addr;
    logic [SIZE-1:0] Aux_W_Data;
    logic            Aux_Ready;
    logic [ADDR-1:0] R_Addr_A;
    logic [ADDR-1:0] R_Addr_B;
    logic            Hazard_A;
    logic            Hazard_B;
    logic            Stall_Req;
    logic [CW-1:0]   Pend_Cnt;
    logic            Write_Reg;
    logic [ADDR-1:0] W_Addr;
    logic [SIZE-1:0] W_Data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    rf_wb_arbiter #(.ADDR(ADDR), .SIZE(SIZE), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .Clk(Clk), .Clr(Clr),
        .Core_Wr_En(Core_Wr_En), .Core_W_Addr(Core_W_Addr), .Core_W_Data(Core_W_Data),
        .Aux_Valid(Aux_Valid), .Aux_W_Addr(Aux_W_Addr), .Aux_W_Data(Aux_W_Data),
        .Aux_Ready(Aux_Ready), .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B),
        .Hazard_A(Hazard_A), .Hazard_B(Hazard_B), .Stall_Req(Stall_Req), .Pend_Cnt(Pend_Cnt),
        .Write_Reg(Write_Reg), .W_Addr(W_Addr), .W_Data(W_Data)
    );

    // Apply one cycle of inputs, then wait to the sampling point mid-cycle.
    task automatic drive(input logic clr, input logic cen, input logic [ADDR-1:0] ca,
                         input logic [SIZE-1:0] cd, input logic av, input logic [ADDR-1:0] aa,
                         input logic [SIZE-1:0] ad, input logic [ADDR-1:0] ra,
                         input logic [ADDR-1:0] rb);
        Clr = clr; Core_Wr_En = cen; Core_W_Addr = ca; Core_W_Data = cd;
        Aux_Valid = av; Aux_W_Addr = aa; Aux_W_Data = ad; R_Addr_A = ra; R_Addr_B = rb;
        @(negedge Clk);
    endtask

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1, 5'd5, 5'd5);
            n_cmp++;
            if ({Write_Reg, Aux_Ready, Pend_Cnt, Stall_Req, Hazard_A, Hazard_B} !== 8'd0) begin
                n_err++;
                $display("FAIL reset_outputs cyc%0d: wr=%b rdy=%b pend=%0d stall=%b haz=%b%b, want all 0",
                         c, Write_Reg, Aux_Ready, Pend_Cnt, Stall_Req, Hazard_A, Hazard_B);
            end
            next_cycle();
        end
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        n_cmp++;
        if ({Aux_Ready, Pend_Cnt, Write_Reg} !== {1'b1, 3'd0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_release: rdy=%b pend=%0d wr=%b, want rdy=1 pend=0 wr=0",
                     Aux_Ready, Pend_Cnt, Write_Reg);
        end
        next_cycle();
    endtask

    task automatic test_aux_push();
        logic cen;
        cen = BYP;  // with bypass built in, a busy core forces the aux result into the FIFO
        drive(1'b0, cen, 5'd9, 32'h9999, 1'b1, 5'd5, 32'h1234, 5'd5, 5'd6);
        n_cmp++;
        if ({Write_Reg, Pend_Cnt, Hazard_A} !== {cen, 3'd0, 1'b0}) begin
            n_err++;
            $display("FAIL push_accept: wr=%b pend=%0d hazA=%b, want wr=%b pend=0 hazA=0",
                     Write_Reg, Pend_Cnt, Hazard_A, cen);
        end
        next_cycle();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd6);
        n_cmp++;
        if ({Write_Reg, W_Addr, W_Data} !== {1'b1, 5'd5, 32'h1234}) begin
            n_err++;
            $display("FAIL push_drain_write: wr=%b addr=%0d data=%h, want 1 5 00001234",
                     Write_Reg, W_Addr, W_Data);
        end
        n_cmp++;
        if ({Hazard_A, Hazard_B, Pend_Cnt} !== {1'b1, 1'b0, 3'd1}) begin
            n_err++;
            $display("FAIL push_hazard: hazA=%b hazB=%b pend=%0d, want 1 0 1", Hazard_A, Hazard_B, Pend_Cnt);
        end
        next_cycle();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd6);
        n_cmp++;
        if ({Write_Reg, Hazard_A, Pend_Cnt} !== {1'b0, 1'b0, 3'd0}) begin
            n_err++;
            $display("FAIL push_drained: wr=%b hazA=%b pend=%0d, want 0 0 0", Write_Reg, Hazard_A, Pend_Cnt);
        end
        next_cycle();
    endtask

    task automatic test_fill_contention();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 1'b1, 5'd9, 32'(32'h900 + i), 1'b1, 5'(i), 32'(32'h100 + i), 5'd0, 5'd0);
            n_cmp++;
            if ({Write_Reg, W_Addr, W_Data, Aux_Ready, Pend_Cnt} !== {1'b1, 5'd9, 32'(32'h900 + i), 1'b1, 3'(i - 1)}) begin
                n_err++;
                $display("FAIL fill_%0d: wr=%b addr=%0d data=%h rdy=%b pend=%0d, want 1 9 %h 1 %0d",
                         i, Write_Reg, W_Addr, W_Data, Aux_Ready, Pend_Cnt, 32'h900 + i, i - 1);
            end
            next_cycle();
        end
        drive(1'b0, 1'b1, 5'd9, 32'h905, 1'b1, 5'd5, 32'h105, 5'd0, 5'd0);
        n_cmp++;
        if ({Aux_Ready, Pend_Cnt, Write_Reg, W_Addr, W_Data} !== {1'b0, 3'd4, 1'b1, 5'd9, 32'h905}) begin
            n_err++;
            $display("FAIL fill_full: rdy=%b pend=%0d wr=%b addr=%0d data=%h, want 0 4 1 9 905",
                     Aux_Ready, Pend_Cnt, Write_Reg, W_Addr, W_Data);
        end
        next_cycle();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd4, 5'd5);
            n_cmp++;
            if ({Write_Reg, W_Addr, W_Data, Pend_Cnt, Hazard_A, Hazard_B} !== {1'b1, 5'(i), 32'(32'h100 + i), 3'(5 - i), 1'b1, 1'b0}) begin
                n_err++;
                $display("FAIL drain_%0d: wr=%b addr=%0d data=%h pend=%0d haz=%b%b, want 1 %0d %h %0d 10",
                         i, Write_Reg, W_Addr, W_Data, Pend_Cnt, Hazard_A, Hazard_B, i, 32'h100 + i, 5 - i);
            end
            next_cycle();
        end
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd4, 5'd5);
        n_cmp++;
        if ({Write_Reg, Pend_Cnt} !== {1'b0, 3'd0}) begin
            n_err++;
            $display("FAIL drain_done: wr=%b pend=%0d, want 0 0", Write_Reg, Pend_Cnt);
        end
        next_cycle();
    endtask

    task automatic test_kill();
        drive(1'b0, 1'b1, 5'd9, 32'h9, 1'b1, 5'd7, 32'hAA, 5'd7, 5'd0);
        n_cmp++;
        if ({Hazard_A, Pend_Cnt} !== {1'b0, 3'd0}) begin
            n_err++;
            $display("FAIL kill_push: hazA=%b pend=%0d, want 0 0", Hazard_A, Pend_Cnt);
        end
        next_cycle();
        drive(1'b0, 1'b1, 5'd7, 32'hBB, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
        n_cmp++;
        if ({Hazard_A, Write_Reg, W_Addr, W_Data} !== {1'b1, 1'b1, 5'd7, 32'hBB}) begin
            n_err++;
            $display("FAIL kill_core_write: hazA=%b wr=%b addr=%0d data=%h, want 1 1 7 bb",
                     Hazard_A, Write_Reg, W_Addr, W_Data);
        end
        next_cycle();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
        n_cmp++;
        if ({Hazard_A, Pend_Cnt, Write_Reg} !== {1'b0, 3'd1, 1'b0}) begin
            n_err++;
            $display("FAIL kill_pop_nowrite: hazA=%b pend=%0d wr=%b, want 0 1 0", Hazard_A, Pend_Cnt, Write_Reg);
        end
        next_cycle();
        drive(1'b0, 1'b1, 5'd7, 32'hDD, 1'b1, 5'd7, 32'hCC, 5'd7, 5'd0);
        n_cmp++;
        if ({Pend_Cnt, Write_Reg, W_Addr, W_Data} !== {3'd0, 1'b1, 5'd7, 32'hDD}) begin
            n_err++;
            $display("FAIL kill_same_edge: pend=%0d wr=%b addr=%0d data=%h, want 0 1 7 dd",
                     Pend_Cnt, Write_Reg, W_Addr, W_Data);
        end
        next_cycle();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
        n_cmp++;
        if ({Hazard_A, Pend_Cnt, Write_Reg} !== {1'b0, 3'd1, 1'b0}) begin
            n_err++;
            $display("FAIL kill_same_edge_pop: hazA=%b pend=%0d wr=%b, want 0 1 0", Hazard_A, Pend_Cnt, Write_Reg);
        end
        next_cycle();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
        n_cmp++;
        if (Pend_Cnt !== 3'd0) begin
            n_err++;
            $display("FAIL kill_empty: pend=%0d, want 0", Pend_Cnt);
        end
        next_cycle();
    endtask

    task automatic test_starvation();
        drive(1'b0, 1'b1, 5'd9, 32'h0, 1'b1, 5'd12, 32'hC0DE, 5'd12, 5'd0);
        next_cycle();
        for (int i = 1; i <= STARVE_MAX; i++) begin
            drive(1'b0, 1'b1, 5'd9, 32'(i), 1'b0, 5'd0, 32'd0, 5'd12, 5'd0);
            n_cmp++;
            if ({Stall_Req, Write_Reg, W_Addr, Hazard_A, Pend_Cnt} !== {1'b0, 1'b1, 5'd9, 1'b1, 3'd1}) begin
                n_err++;
                $display("FAIL starve_block_%0d: stall=%b wr=%b addr=%0d hazA=%b pend=%0d, want 0 1 9 1 1",
                         i, Stall_Req, Write_Reg, W_Addr, Hazard_A, Pend_Cnt);
            end
            next_cycle();
        end
        drive(1'b0, 1'b1, 5'd9, 32'h9, 1'b0, 5'd0, 32'd0, 5'd12, 5'd0);
        n_cmp++;
        if ({Stall_Req, Write_Reg, W_Addr, W_Data} !== {1'b1, 1'b1, 5'd12, 32'hC0DE}) begin
            n_err++;
            $display("FAIL starve_force: stall=%b wr=%b addr=%0d data=%h, want 1 1 12 c0de",
                     Stall_Req, Write_Reg, W_Addr, W_Data);
        end
        next_cycle();
        drive(1'b0, 1'b1, 5'd9, 32'h9, 1'b0, 5'd0, 32'd0, 5'd12, 5'd0);
        n_cmp++;
        if ({Stall_Req, Write_Reg, W_Addr, W_Data, Pend_Cnt, Hazard_A} !== {1'b0, 1'b1, 5'd9, 32'h9, 3'd0, 1'b0}) begin
            n_err++;
            $display("FAIL starve_release: stall=%b wr=%b addr=%0d data=%h pend=%0d hazA=%b, want 0 1 9 9 0 0",
                     Stall_Req, Write_Reg, W_Addr, W_Data, Pend_Cnt, Hazard_A);
        end
        next_cycle();
    endtask

    task automatic test_bypass();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h55, 5'd3, 5'd0);
        n_cmp++;
        if ({Write_Reg, Aux_Ready, Pend_Cnt} !== {BYP, 1'b1, 3'd0}) begin
            n_err++;
            $display("FAIL bypass_same_cycle: wr=%b rdy=%b pend=%0d, want %b 1 0", Write_Reg, Aux_Ready, Pend_Cnt, BYP);
        end
        if (BYP) begin
            n_cmp++;
            if ({W_Addr, W_Data} !== {5'd3, 32'h55}) begin
                n_err++;
                $display("FAIL bypass_data: addr=%0d data=%h, want 3 55", W_Addr, W_Data);
            end
        end
        next_cycle();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0);
        n_cmp++;
        if ({Write_Reg, Pend_Cnt} !== {!BYP, BYP ? 3'd0 : 3'd1}) begin
            n_err++;
            $display("FAIL bypass_next: wr=%b pend=%0d, want %b %0d", Write_Reg, Pend_Cnt, !BYP, BYP ? 0 : 1);
        end
        if (!BYP) begin
            n_cmp++;
            if ({W_Addr, W_Data} !== {5'd3, 32'h55}) begin
                n_err++;
                $display("FAIL bypass_queued_data: addr=%0d data=%h, want 3 55", W_Addr, W_Data);
            end
        end
        next_cycle();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0);
        next_cycle();
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b1, 5'd9, 32'h1, 1'b1, 5'd20, 32'h20, 5'd20, 5'd21);
        next_cycle();
        drive(1'b0, 1'b1, 5'd9, 32'h2, 1'b1, 5'd21, 32'h21, 5'd20, 5'd21);
        next_cycle();
        drive(1'b1, 1'b1, 5'd9, 32'h3, 1'b1, 5'd22, 32'h22, 5'd20, 5'd21);
        n_cmp++;
        if ({Write_Reg, Hazard_A, Hazard_B, Aux_Ready, Stall_Req, Pend_Cnt} !== {5'b00000, 3'd2}) begin
            n_err++;
            $display("FAIL reset_mid: wr=%b haz=%b%b rdy=%b stall=%b pend=%0d, want 0 00 0 0 2",
                     Write_Reg, Hazard_A, Hazard_B, Aux_Ready, Stall_Req, Pend_Cnt);
        end
        next_cycle();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd20, 5'd21);
        n_cmp++;
        if ({Write_Reg, Hazard_A, Hazard_B, Pend_Cnt} !== {3'b000, 3'd0}) begin
            n_err++;
            $display("FAIL reset_mid_after: wr=%b haz=%b%b pend=%0d, want 0 00 0",
                     Write_Reg, Hazard_A, Hazard_B, Pend_Cnt);
        end
        next_cycle();
    endtask

    typedef struct {
        bit              live;
        logic [ADDR-1:0] addr;
        logic [SIZE-1:0] data;
    } ent_t;

    task automatic test_random();
        ent_t q[$];
        int   starve;
        bit   forcing;
        bit   hot;
        logic clr, cen, av;
        logic [ADDR-1:0] ca, aa, ra, rb;
        logic [SIZE-1:0] cd, ad;
        logic e_wr, e_rdy, e_ha, e_hb, e_st;
        logic [ADDR-1:0] e_wa;
        logic [SIZE-1:0] e_wd;
        logic [CW-1:0]   e_pc;
        bit was_empty, head_live0, popped, bypassed, kill;

        drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        next_cycle();
        starve = 0; forcing = 0; hot = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 40 == 0) hot = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 149) == 0);
            cen = hot ? ($urandom_range(0, 19) != 0) : 1'($urandom_range(0, 1));
            av  = 1'($urandom_range(0, 1));
            ca  = 5'($urandom_range(0, 7));
            aa  = 5'($urandom_range(0, 7));
            ra  = 5'($urandom_range(0, 7));
            rb  = 5'($urandom_range(0, 7));
            cd  = $urandom;
            ad  = $urandom;

            e_wr = 0; e_wa = '0; e_wd = '0; e_rdy = 0; e_ha = 0; e_hb = 0; e_st = 0;
            e_pc = CW'(q.size());
            if (clr) begin
                q.delete();
                starve = 0;
                forcing = 0;
            end else begin
                e_rdy = (q.size() < DEPTH);
                e_st  = forcing;
                foreach (q[j]) begin
                    if (q[j].live && q[j].addr == ra) e_ha = 1;
                    if (q[j].live && q[j].addr == rb) e_hb = 1;
                end
                was_empty  = (q.size() == 0);
                head_live0 = !was_empty && q[0].live;
                popped = 0; bypassed = 0; kill = 0;
                if (forcing) begin
                    if (!was_empty) begin
                        if (q[0].live) begin e_wr = 1; e_wa = q[0].addr; e_wd = q[0].data; end
                        void'(q.pop_front());
                        popped = 1;
                    end
                end else if (cen) begin
                    e_wr = 1; e_wa = ca; e_wd = cd; kill = 1;
                    if (!was_empty && !q[0].live) begin void'(q.pop_front()); popped = 1; end
                end else if (!was_empty) begin
                    if (q[0].live) begin e_wr = 1; e_wa = q[0].addr; e_wd = q[0].data; end
                    void'(q.pop_front());
                    popped = 1;
                end else if (BYP && av) begin
                    e_wr = 1; e_wa = aa; e_wd = ad; bypassed = 1;
                end
                if (kill) foreach (q[j]) if (q[j].addr == ca) q[j].live = 0;
                if (av && e_rdy && !bypassed) q.push_back('{live: !(kill && aa == ca), addr: aa, data: ad});
                if (forcing) begin
                    forcing = 0;
                    starve = 0;
                end else if (popped || was_empty) begin
                    starve = 0;
                end else if (head_live0 && cen) begin
                    starve++;
                    if (starve == STARVE_MAX) forcing = 1;
                end
            end

            drive(clr, cen, ca, cd, av, aa, ad, ra, rb);
            n_cmp++;
            if (Write_Reg !== e_wr) begin
                n_err++;
                $display("FAIL rnd_write_en cyc%0d: got %b want %b", cyc, Write_Reg, e_wr);
            end
            if (e_wr || clr) begin
                n_cmp++;
                if ({W_Addr, W_Data} !== {e_wa, e_wd}) begin
                    n_err++;
                    $display("FAIL rnd_write_data cyc%0d: got %0d/%h want %0d/%h", cyc, W_Addr, W_Data, e_wa, e_wd);
                end
            end
            n_cmp++;
            if ({Aux_Ready, Stall_Req, Pend_Cnt} !== {e_rdy, e_st, e_pc}) begin
                n_err++;
                $display("FAIL rnd_status cyc%0d: rdy/stall/pend got %b/%b/%0d want %b/%b/%0d",
                         cyc, Aux_Ready, Stall_Req, Pend_Cnt, e_rdy, e_st, e_pc);
            end
            n_cmp++;
            if ({Hazard_A, Hazard_B} !== {e_ha, e_hb}) begin
                n_err++;
                $display("FAIL rnd_hazard cyc%0d: got %b%b want %b%b", cyc, Hazard_A, Hazard_B, e_ha, e_hb);
            end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_aux_push();
        test_fill_contention();
        test_kill();
        test_starvation();
        test_bypass();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Owns the single write port of the 32x32 register file and shares it between two sources: the core writeback path and a multi-cycle unit (mul/div, slow load) that returns results late.
- Core writes are granted immediately. Auxiliary results queue in a small FIFO and drain into idle write-port cycles.
- Provides per-read-port hazard flags for destinations still pending, plus a starvation stall request to the core.

Parameters:
- ADDR, 5, register address width.
- SIZE, 32, data width.
- DEPTH, 4, aux FIFO entries (power of 2, >=2).
- STARVE_MAX, 8, consecutive blocked cycles before Stall_Req asserts.

Ports:
- Clk  in  1  clock, all state updates on posedge.
- Clr  in  1  synchronous active-high reset.
- Core_Wr_En  in  1  core writeback request.
- Core_W_Addr  in  ADDR  core destination register.
- Core_W_Data  in  SIZE  core write data.
- Aux_Valid  in  1  aux result valid.
- Aux_W_Addr  in  ADDR  aux destination register.
- Aux_W_Data  in  SIZE  aux result data.
- Aux_Ready  out  1  FIFO can accept (= !full && !Clr).
- R_Addr_A  in  ADDR  read port A address, for hazard check.
- R_Addr_B  in  ADDR  read port B address, for hazard check.
- Hazard_A  out  1  a live pending entry targets R_Addr_A.
- Hazard_B  out  1  a live pending entry targets R_Addr_B.
- Stall_Req  out  1  core must freeze; aux head has priority this cycle.
- Pend_Cnt  out  clog2(DEPTH)+1  FIFO occupancy (live and killed entries).
- Write_Reg  out  1  register file write enable.
- W_Addr  out  ADDR  register file write address.
- W_Data  out  SIZE  register file write data.

Behaviour:
Clock, reset and outputs:
- One clock, Clk; reset Clr is synchronous and active-high.
- The write-port outputs are combinational from current state and inputs. The register file samples them on the negedge of the same cycle.
- Reset: FIFO pointers, Pend_Cnt, live bits, starve counter and FSM are cleared to state S_NORM.
- While Clr=1: Write_Reg=0, Aux_Ready=0, Hazard_A/B=0, Stall_Req=0. W_Addr/W_Data are don't-care (drive 0).

FIFO:
- Each entry holds {live, addr, data}. Push occurs when Aux_Valid && Aux_Ready at posedge; a pushed entry is live.
- When full, no push is accepted even if the same cycle pops.
- Push and pop in the same cycle leave Pend_Cnt unchanged. Pointers wrap modulo DEPTH.

Write-port grant, S_NORM:
- Core_Wr_En=1: the core is granted (Write_Reg=1, core addr/data). A live head is not popped.
- Core idle, live head present: the head is written and popped.
- Killed head: popped with no write, in any cycle, including core-write cycles.
- Empty FIFO and core idle: Write_Reg=0.

Kill rule:
- A core write granted to address X clears the live bit of every FIFO entry with addr==X, including entries pushed that same edge.
- This keeps the newer core value from being overwritten by an older aux result.

Hazards:
- Hazard_A=1 iff some live entry has addr==R_Addr_A; likewise Hazard_B with R_Addr_B.
- The aux inputs of the current cycle are not included.

Starvation FSM:
- The counter increments each cycle a live head is blocked by a core write; it clears on any head pop or when the FIFO is empty.
- S_NORM -> S_FORCE when the counter reaches STARVE_MAX.
- In S_FORCE:
  - Stall_Req=1.
  - The live head is written and popped regardless of Core_Wr_En. The core holds its write and re-presents it next cycle; no kill is applied for an ignored core write.
  - Next state is S_NORM with the counter cleared.
- Killed-head pop in S_FORCE: the FSM returns to S_NORM with no write.

Reset mid-operation:
- Clr during S_FORCE or with a non-empty FIFO discards all entries. No write is issued in that cycle.

Optional Feature:
- Macro RF_WB_BYPASS_EN.
- Defined: when FIFO empty, Core_Wr_En=0 and Aux_Valid=1 (and Clr=0), the aux addr/data go straight to the write port in the same cycle. Nothing is pushed; Aux_Ready=1.
- Undefined: every aux result is pushed first, so the earliest register-file write is the cycle after acceptance.

Test Plan:
- Reset then idle: Clr=1 for 2 cycles with Aux_Valid=1 -> Write_Reg=0, Aux_Ready=0, Pend_Cnt=0; after release Aux_Ready=1.
- Aux push with core idle (no bypass): push addr 5 data 0x1234 at edge k -> cycle k+1 Write_Reg=1, W_Addr=5, W_Data=0x1234, Hazard_A=1 when R_Addr_A=5 during cycle k+1, Pend_Cnt 1->0.
- Fill and core contention: 4 pushes (addr 1..4) while Core_Wr_En=1 to addr 9 each cycle -> Aux_Ready=0 at Pend_Cnt=4, fifth push refused, no aux write while core writes.
- Kill: pending aux addr 7 data 0xAA, core writes addr 7 data 0xBB -> Hazard on 7 drops next cycle, killed entry popped with no write, register 7 ends 0xBB.
- Starvation: one live entry, Core_Wr_En=1 for 8 consecutive cycles -> Stall_Req=1 in cycle 9, aux head written, core write not performed that cycle, Stall_Req=0 in cycle 10.
- Bypass (RF_WB_BYPASS_EN): empty FIFO, core idle, Aux_Valid addr 3 data 0x55 -> same-cycle Write_Reg=1, W_Addr=3, Pend_Cnt stays 0.
